// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one external memory port between instruction fetch
// and the data stage. The data side has priority, and an anti-starvation counter
// protects fetch. A watchdog aborts bus accesses that never complete.
// Build option: define MEM_ARB_RR_EN to replace the data priority and starve
// counter with strict round-robin arbitration.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  // fetch side
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  // data side
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byte_en,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  // memory port
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byte_en,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  // status
  output logic        bus_err,
  output logic        grant_d
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  state_t      state, state_next;
  logic [15:0] to_cnt;
  logic        take;
  logic        win_i;
  logic        hit_to;

  assign take   = i_req | d_req;
  assign hit_to = (to_cnt == TO_LAST);

`ifdef MEM_ARB_RR_EN
  logic last_d;

  // On contention the side that was not granted last time wins.
  assign win_i = i_req & (~d_req | last_d);

  // Remember which side was granted most recently.
  always_ff @(posedge clk) begin
    if (!reset)                    last_d <= 1'b0;
    else if (state == IDLE && take) last_d <= ~win_i;
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  // Data wins unless fetch has waited through STARVE_LIMIT data grants.
  assign win_i = i_req & (~d_req | (starve_cnt == STARVE_MAX));

  // Count data grants taken while fetch waits; clear when fetch is served or idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!i_req || win_i)
        starve_cnt <= '0;
      else if (d_req && starve_cnt != STARVE_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next is assigned a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = BUSY;
      BUSY:    if (m_ack || hit_to) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch the winner, hold the port, capture the response, and pulse the acks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_byte_en <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_ack     <= 1'b0;
      d_ack     <= 1'b0;
      bus_err   <= 1'b0;
      grant_d   <= 1'b0;
      to_cnt    <= '0;
    end else begin
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (take) begin
            m_req <= 1'b1;
            if (win_i) begin
              grant_d   <= 1'b0;
              m_we      <= 1'b0;
              m_addr    <= i_addr;
              m_wdata   <= '0;
              m_byte_en <= 4'hF;
            end else begin
              grant_d   <= 1'b1;
              m_we      <= d_we;
              m_addr    <= d_addr;
              m_wdata   <= d_wdata;
              m_byte_en <= d_byte_en;
            end
          end
        end
        BUSY: begin
          if (m_ack || hit_to) begin
            m_req   <= 1'b0;
            to_cnt  <= '0;
            bus_err <= ~m_ack;
            if (grant_d) begin
              d_ack   <= 1'b1;
              d_rdata <= m_ack ? m_rdata : ERR_WORD;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= m_ack ? m_rdata : ERR_WORD;
            end
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
        end
        RESP: grant_d <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed test of mem_port_arbiter with STARVE_LIMIT = 4
// and TIMEOUT = 8. The testbench drives and samples signals on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we, m_ack;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_byte_en;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_ack, d_ack, m_req, m_we, bus_err, grant_d;
  logic [3:0]  m_byte_en;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_byte_en(d_byte_en), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_byte_en(m_byte_en), .m_rdata(m_rdata), .m_ack(m_ack),
    .bus_err(bus_err), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {i_req, d_req, d_we, m_ack} = '0;
    {i_addr, d_addr, d_wdata, m_rdata} = '0;
    d_byte_en = '0;
    repeat (2) @(negedge clk);
    check("rst_ctl", {m_req, m_we, i_ack, d_ack, bus_err, grant_d, m_byte_en}, 0);
    check("rst_rdata", {i_rdata, d_rdata}, 0);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Wait for the port request, acknowledge it in the first busy cycle, then
  // check the single ack pulse that follows. The task returns in the response cycle.
  task automatic serve(input logic [31:0] rd, output logic got_d);
    int n = 0;
    while (!m_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    got_d = grant_d;
    if (!m_req) begin
      check("grant_wait", m_req, 1);
      return;
    end
    m_ack   = 1'b1;
    m_rdata = rd;
    @(negedge clk);
    m_ack = 1'b0;
    check("ack_pair", {d_ack, i_ack}, got_d ? 2'b10 : 2'b01);
    check("ack_err", bus_err, 0);
    check("ack_mreq", m_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end (got hang, expected finish)");
    $fatal(1);
  end

  initial begin
    logic g;
    int   cnt;
    logic exp_d;

    do_reset();

    // Fetch read with m_ack two cycles after m_req.
    i_req = 1'b1; i_addr = 32'h0040_0000;
    @(negedge clk);
    check("f_mreq", {m_req, m_we, m_byte_en, grant_d}, {1'b1, 1'b0, 4'hF, 1'b0});
    check("f_addr", m_addr, 32'h0040_0000);
    @(negedge clk);
    check("f_wait", {m_req, i_ack, d_ack}, 3'b100);
    @(negedge clk);
    m_ack = 1'b1; m_rdata = 32'h2008_0005;
    @(negedge clk);
    m_ack = 1'b0; i_req = 1'b0;
    check("f_ack", {i_ack, d_ack, bus_err, m_req}, 4'b1000);
    check("f_rdata", i_rdata, 32'h2008_0005);
    @(negedge clk);
    check("f_ack_once", {i_ack, d_ack, m_req}, 0);

    // A data read leaves i_rdata untouched.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000_0000;
    serve(32'h5555_AAAA, g);
    d_req = 1'b0;
    check("d_grant", g, 1);
    check("rdata_hold", {i_rdata, d_rdata}, {32'h2008_0005, 32'h5555_AAAA});

    // Ignore a spurious m_ack while idle.
    @(negedge clk);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    check("sp_idle", {i_ack, d_ack, m_req, bus_err}, 0);
    // Ignore a spurious m_ack during the response cycle.
    i_req = 1'b1; i_addr = 32'h0040_0004;
    @(negedge clk);
    check("sp_lat", {m_req, grant_d}, 2'b10);
    m_ack = 1'b1; m_rdata = 32'h0000_0013;
    @(negedge clk);
    i_req = 1'b0;
    check("sp_ack", {i_ack, d_ack}, 2'b10);
    @(negedge clk);
    m_ack = 1'b0;
    check("sp_resp", {i_ack, d_ack, m_req, bus_err}, 0);
    @(negedge clk);
    check("sp_idle2", {i_ack, d_ack, m_req}, 0);

    // A data write contends with a fetch; data wins first, then fetch is served.
    do_reset();
    i_req = 1'b1; i_addr = 32'h0040_0100;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0010;
    d_wdata = 32'hCAFE_F00D; d_byte_en = 4'b0011;
    @(negedge clk);
    check("c_wr_ctl", {m_req, m_we, m_byte_en, grant_d}, {1'b1, 1'b1, 4'b0011, 1'b1});
    check("c_wr_bus", {m_addr, m_wdata}, {32'h1000_0010, 32'hCAFE_F00D});
    serve(32'h0, g);
    d_req = 1'b0;
    check("c_first_d", g, 1);
    serve(32'h1234_5678, g);
    i_req = 1'b0;
    check("c_then_i", g, 0);
    check("c_i_rdata", i_rdata, 32'h1234_5678);

    // Starvation: both sides keep requesting.
    do_reset();
    i_req = 1'b1; i_addr = 32'h0040_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0020; d_byte_en = 4'hF;
    for (int k = 0; k < 16; k++) begin
`ifdef MEM_ARB_RR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = (k % 5 != 4);
`endif
      serve(32'(k), g);
      check($sformatf("starve_%0d", k), g, exp_d);
    end
    i_req = 1'b0; d_req = 1'b0;

    // Timeout: the memory never acknowledges.
    do_reset();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1000_0030;
    cnt = 0;
    while (!m_req && cnt < 5) begin @(negedge clk); cnt++; end
    cnt = 0;
    while (m_req && cnt < 40) begin @(negedge clk); cnt++; end
    d_req = 1'b0;
    check("to_len", cnt, 8);
    check("to_ack", {d_ack, bus_err, i_ack}, 3'b110);
    check("to_rdata", d_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("to_once", {d_ack, bus_err}, 0);
    d_req = 1'b1;
    serve(32'h0BAD_F00D, g);
    d_req = 1'b0;
    check("to_recover", d_rdata, 32'h0BAD_F00D);

    // Assert reset in the second busy cycle of a data read.
    d_req = 1'b1; d_addr = 32'h1000_0040;
    cnt = 0;
    while (!m_req && cnt < 5) begin @(negedge clk); cnt++; end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    d_req = 1'b0;
    check("mr_ctl", {m_req, m_we, i_ack, d_ack, bus_err, grant_d, m_byte_en}, 0);
    check("mr_bus", {m_addr, m_wdata}, 0);
    check("mr_rdata", {i_rdata, d_rdata}, 0);
    @(negedge clk);
    check("mr_noack", {d_ack, m_req}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("mr_noack2", {d_ack, m_req}, 0);
    i_req = 1'b1; i_addr = 32'h0040_0300;
    serve(32'h600D_0001, g);
    i_req = 1'b0;
    check("mr_fetch", {31'(0), g}, 0);
    check("mr_i_rdata", i_rdata, 32'h600D_0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
